// File: rtl/fib_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fib_scheduler
// Purpose  : Round-robin scheduler sharing one fibonacci engine between NREQ
//            requesters. Each job: arbitrate, clear engine, pulse start with
//            the latched operand, wait for done (bounded by TIMEOUT), return
//            the result to the granted requester.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-low reset
//            req          - per-requester request level
//            req_din      - packed operands, requester i at [i*WIDTH +: WIDTH]
//            rsp_valid    - one-hot completion pulse
//            rsp_dout     - job result (valid with rsp_valid)
//            rsp_timeout  - job was aborted by the timeout
//            busy         - scheduler is not idle
//            fib_reset    - engine clear (active high)
//            fib_din      - engine operand
//            fib_start    - engine start pulse
//            fib_dout     - engine result
//            fib_done     - engine completion (level or pulse)
// Revision : 1.0 - initial release
// ============================================================================
module fib_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_din,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_dout,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  fib_reset,
    output logic [WIDTH-1:0]      fib_din,
    output logic                  fib_start,
    input  logic [WIDTH-1:0]      fib_dout,
    input  logic                  fib_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   C_CNT_MAX  = CW'(TIMEOUT);
    localparam logic [NREQ-1:0] C_ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // (base + off) mod NREQ, both operands already < NREQ
    function automatic logic [PW-1:0] f_wrap_add(input logic [PW-1:0] base,
                                                 input logic [PW-1:0] off);
        logic [PW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= (PW+1)'(NREQ)) begin
            s = s - (PW+1)'(NREQ);
        end
        return s[PW-1:0];
    endfunction

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_dout;
    logic              r_rsp_timeout;
    logic              r_busy;
    logic              r_fib_reset;
    logic              r_fib_start;
    logic [WIDTH-1:0]  r_fib_din;

    state_t            w_state_nxt;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_idx_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [NREQ-1:0]   w_rsp_valid_nxt;
    logic [WIDTH-1:0]  w_rsp_dout_nxt;
    logic              w_rsp_timeout_nxt;
    logic              w_fib_reset_nxt;
    logic              w_fib_start_nxt;
    logic [WIDTH-1:0]  w_fib_din_nxt;

    logic [2*NREQ-1:0] w_req_rot;
    logic              w_grant_found;
    logic [PW-1:0]     w_grant_off;
    logic [PW-1:0]     w_grant_idx;
    logic [WIDTH-1:0]  w_grant_din;

    // Rotating the request vector so bit 0 is the pointer position turns the
    // round-robin search into a plain lowest-set-bit search.
    assign w_req_rot = {req, req} >> r_ptr;

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_grant_found && w_req_rot[i]) begin
                w_grant_found = 1'b1;
                w_grant_off   = PW'(i);
            end
        end
    end

    assign w_grant_idx = f_wrap_add(r_ptr, w_grant_off);

    always_comb begin
        w_grant_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == PW'(i)) begin
                w_grant_din = req_din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pulse-type outputs default to zero so they last exactly one cycle;
    // fib_din holds its value until the next grant.
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_rsp_valid_nxt   = '0;
        w_rsp_dout_nxt    = '0;
        w_rsp_timeout_nxt = 1'b0;
        w_fib_reset_nxt   = 1'b0;
        w_fib_start_nxt   = 1'b0;
        w_fib_din_nxt     = r_fib_din;

        case (r_state)
            S_IDLE: begin
                if (w_grant_found) begin
                    w_state_nxt     = S_CLR;
                    w_idx_nxt       = w_grant_idx;
                    w_fib_din_nxt   = w_grant_din;
                    w_fib_reset_nxt = 1'b1;
                end
            end
            S_CLR: begin
                w_state_nxt     = S_START;
                w_fib_start_nxt = 1'b1;
            end
            S_START: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (r_cnt != C_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                // done wins over a timeout landing in the same cycle
                if (fib_done) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = C_ONE_HOT0 << r_idx;
                    w_rsp_dout_nxt  = fib_dout;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = C_ONE_HOT0 << r_idx;
                    w_rsp_dout_nxt    = '1;
                    w_rsp_timeout_nxt = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = f_wrap_add(r_idx, PW'(1));
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_dout    <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_fib_reset   <= 1'b0;
            r_fib_start   <= 1'b0;
            r_fib_din     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_dout    <= w_rsp_dout_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_fib_reset   <= w_fib_reset_nxt;
            r_fib_start   <= w_fib_start_nxt;
            r_fib_din     <= w_fib_din_nxt;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_dout    = r_rsp_dout;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;
    assign fib_reset   = r_fib_reset;
    assign fib_start   = r_fib_start;
    assign fib_din     = r_fib_din;

endmodule
`default_nettype wire

// File: doc/fib_scheduler.md
Name: fib_scheduler

Overview:
- Round-robin scheduler that shares one fibonacci engine between NREQ independent requesters.
- Each job runs the same way: arbitrate, clear the engine, pulse start with the latched operand, wait for done (bounded by a timeout), then return the result to the granted requester.
- Sits between requester logic and a single fibonacci instance. It owns that instance's reset, din and start inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width; matches the engine's din/dout.
- TIMEOUT, 64, maximum WAIT cycles before a job is aborted (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; held high with stable operand until served.
- req_din  input  NREQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
- rsp_valid  output  NREQ  one-hot, one-cycle pulse marking which requester's job completed.
- rsp_dout  output  WIDTH  result; valid only while rsp_valid != 0.
- rsp_timeout  output  1  high with rsp_valid when the job was aborted.
- busy  output  1  high in every state except IDLE.
- fib_reset  output  1  active-high clear to the engine.
- fib_din  output  WIDTH  engine operand.
- fib_start  output  1  engine start pulse.
- fib_dout  input  WIDTH  engine result.
- fib_done  input  1  engine completion (level or pulse both accepted).

Behaviour:
- All outputs are registered.
- Reset values (reset=0, asynchronous): state=IDLE, rsp_valid=0, rsp_dout=0, rsp_timeout=0, busy=0, fib_reset=0, fib_start=0, fib_din=0, rr pointer=0, timeout counter=0.
- States:
  - IDLE: if any req is high, select the first set index searching ptr, ptr+1, ..., wrapping mod NREQ. Latch idx and req_din[idx] into fib_din. Go to CLR. If no req is high, stay in IDLE.
  - CLR: fib_reset=1 for exactly one cycle. Go to START.
  - START: fib_start=1 for exactly one cycle, fib_din stable. Clear the counter. Go to WAIT. fib_done is ignored in CLR and START, so stale done from a prior job is masked.
  - WAIT: counter increments each cycle.
    - If fib_done=1: capture fib_dout into rsp_dout, rsp_timeout=0, go to RESP.
    - Else if counter == TIMEOUT-1: rsp_dout=all-ones, rsp_timeout=1, go to RESP.
    - fib_done has priority over timeout when both occur in the same cycle.
  - RESP: rsp_valid[idx]=1 for one cycle. ptr <= (idx+1) mod NREQ. Go to IDLE.
- Clearing after RESP: rsp_valid, rsp_timeout and rsp_dout return to 0 in the following cycle.
- fib_din holds the latched operand from the IDLE grant until the next grant. Requester changes to req_din after grant have no effect on the running job.
- Latency: with req high in IDLE at edge k:
  - fib_reset is high during cycle k+1.
  - fib_start is high during cycle k+2.
  - WAIT begins at k+3.
  - rsp_valid is high the cycle after fib_done is sampled.
  - Minimum job turnaround is 5 cycles (the fourth edge after the grant edge), giving back-to-back jobs every 5+ cycles.
- req dropped before the IDLE grant: no job is issued for that requester. req dropped after grant: the job still completes and rsp_valid is still pulsed.
- A requester keeping req high after rsp_valid is treated as a new request. It is served only after any other pending requesters, per the rr pointer.
- Reset asserted in any state aborts the job immediately: no rsp_valid, all outputs go to their reset values. The first job after reset release arbitrates from ptr=0.
- Timeout counter width is clog2(TIMEOUT+1) and it never wraps.

Test Plan:
- Single job: req[0]=1, din0=10, engine model correct → rsp_valid=4'b0001, rsp_dout=55, rsp_timeout=0; fib_reset and fib_start each seen for exactly 1 cycle, in order.
- Boundary operands: din=0 → 0; din=1 → 1; din=24 → 46368. Each matches the software recurrence F0=0, F1=1.
- Fairness: req[1] and req[3] held continuously (din 5 and 7, NREQ=4) → responses alternate 1,3,1,3 with dout 5,13,5,13; no starvation across 8 jobs.
- Simultaneous arrival: req=4'b0101 in IDLE at ptr=0 → requester 0 is served first, then 2; next grant searches from ptr=3.
- Timeout: TIMEOUT=8, engine stub never asserts done → rsp_timeout=1 and rsp_dout=16'hFFFF exactly 8 WAIT cycles after START; the next job (din=6) returns 8 correctly.
- Reset mid-WAIT: reset=0 for 2 cycles during a din=20 job → all outputs 0, no rsp_valid; a re-issued din=20 request returns 6765.
